// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - tick-driven UART transmit controller
module uart_tx_ctrl #(
  parameter int NB_DATA      = 8,
  parameter int OVERSAMPLING = 16,
  parameter int SB_TICK      = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_tx_ready,
  output logic               o_tx_done
);

  localparam int MAX_TICK = (OVERSAMPLING > SB_TICK) ? OVERSAMPLING : SB_TICK;
  localparam int CNT_W    = (MAX_TICK > 2) ? $clog2(MAX_TICK) : 1;
  localparam int IDX_W    = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [CNT_W-1:0] OS_LAST  = CNT_W'(OVERSAMPLING - 1);
  localparam logic [CNT_W-1:0] SB_LAST  = CNT_W'(SB_TICK - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB_DATA - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   tick_cnt, tick_cnt_next;
  logic [IDX_W-1:0]   bit_idx, bit_idx_next;
  logic [NB_DATA-1:0] shreg, shreg_next;
  logic               parity, parity_next;
  logic               tx_reg, tx_next;
  logic               done_reg, done_next;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      parity   <= 1'b0;
      tx_reg   <= 1'b1;
      done_reg <= 1'b0;
    end else begin
      state    <= state_next;
      tick_cnt <= tick_cnt_next;
      bit_idx  <= bit_idx_next;
      shreg    <= shreg_next;
      parity   <= parity_next;
      tx_reg   <= tx_next;
      done_reg <= done_next;
    end
  end

  always_comb begin
    state_next    = state;
    tick_cnt_next = tick_cnt;
    bit_idx_next  = bit_idx;
    shreg_next    = shreg;
    parity_next   = parity;
    done_next     = 1'b0;
    tx_next       = 1'b1;

    case (state)
      IDLE: begin
        if (i_tx_start) begin
          shreg_next  = i_data;
          parity_next = (^i_data) ^ (PARITY_ODD != 0);
          state_next  = START;
        end
      end
      START: begin
        if (i_tick) begin
          if (tick_cnt == OS_LAST) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (tick_cnt == OS_LAST) begin
            shreg_next = shreg >> 1;
            if (bit_idx == IDX_LAST) begin
              state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_idx_next  = bit_idx + 1'b1;
              tick_cnt_next = '0;
            end
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (i_tick) begin
          if (tick_cnt == OS_LAST) begin
            state_next = STOP;
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (i_tick) begin
          if (tick_cnt == SB_LAST) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_next != state) begin
      tick_cnt_next = '0;
    end

    // Line level is derived from the state being entered so o_tx changes on that same edge
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase
  end

  assign o_tx       = tx_reg;
  assign o_tx_ready = (state == IDLE);
  assign o_tx_done  = done_reg;

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Tick-driven UART transmit controller. Serialises one data word per handshake onto the TX line.
- Consumes the single-cycle oversampling tick produced by the baud rate generator. Holds each line level for a fixed number of ticks (start, data, optional parity, stop).
- Sits between the baud rate generator and the top-level TX pin. Fed by a FIFO or a command sequencer through a valid/ready handshake.

Parameters:
NB_DATA, 8, data bits per frame (5..9), sent LSB first
OVERSAMPLING, 16, ticks per start/data/parity bit; must match the generator's OVERSAMPLING
SB_TICK, 16, ticks in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2)
PARITY_EN, 0, 1 = insert parity bit after the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even parity (ignored when PARITY_EN = 0)

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_tick  in  1  one-cycle oversampling tick from the baud rate generator
i_tx_start  in  1  request to send i_data; accepted when o_tx_ready = 1
i_data  in  NB_DATA  word to send, sampled on acceptance
o_tx  out  1  serial line, registered, idle high
o_tx_ready  out  1  controller idle and able to accept a word
o_tx_done  out  1  one-cycle pulse when the stop period completes

Behaviour:
- Reset (async, active-high):
  - state = IDLE, o_tx = 1, o_tx_ready = 1, o_tx_done = 0.
  - Tick counter, bit index and shift register cleared.
  - Reset asserted mid-frame aborts the frame. o_tx returns high immediately, with no partial stop period.
- States: IDLE, START, DATA, PARITY, STOP.
- Tick counter: width clogb2(max(OVERSAMPLING, SB_TICK) - 1). Advances only on cycles with i_tick = 1. Cleared on every state change.
- IDLE:
  - o_tx = 1, o_tx_ready = 1.
  - On i_tx_start = 1: latch i_data into the shift register, compute parity over i_data, go to START.
  - From the next cycle: o_tx = 0, o_tx_ready = 0.
- START: o_tx = 0. On i_tick with counter == OVERSAMPLING-1, go to DATA with bit index = 0.
- DATA:
  - o_tx = shift register bit 0.
  - On i_tick with counter == OVERSAMPLING-1: shift right, bit index + 1.
  - After bit NB_DATA-1, go to PARITY if PARITY_EN, else STOP.
- PARITY:
  - o_tx = XOR of the data bits, inverted when PARITY_ODD.
  - On i_tick with counter == OVERSAMPLING-1, go to STOP.
- STOP:
  - o_tx = 1.
  - On i_tick with counter == SB_TICK-1, go to IDLE and pulse o_tx_done for exactly that one cycle.
  - o_tx_ready = 1 from the following cycle.
- o_tx is registered: it changes on the clock edge that enters the new state.
- Bit timing:
  - The first bit is not phase-aligned to i_tick, so the start bit lasts between (OVERSAMPLING-1) and OVERSAMPLING tick periods.
  - Every later bit lasts exactly OVERSAMPLING tick periods. Stop lasts exactly SB_TICK tick periods.
- i_tx_start is ignored while o_tx_ready = 0. i_data changes during a frame have no effect.
- Back-to-back frames: i_tx_start held high is accepted in the first cycle o_tx_ready = 1. That gives one idle-high cycle between the stop period and the next start bit.
- i_tick asserted on the acceptance cycle is not counted. Counting begins in START.

Test Plan:
- Tick every 4 clocks, NB_DATA=8, no parity; send 0xA5 -> o_tx = 0, then 1,0,1,0,0,1,0,1, then 1. Each data bit lasts 64 clocks. o_tx_done pulses once, 64 clocks after the last data bit ends. o_tx_ready is 0 throughout the frame.
- PARITY_EN=1: send 0x07 with PARITY_ODD=0 -> parity bit 1. Send 0x07 with PARITY_ODD=1 -> parity bit 0. Send 0x00 with even parity -> parity bit 0. Frame is 11 bits long.
- Hold i_tx_start=1 with 0x55 then 0x3C -> two frames. Exactly one idle-high cycle separates the stop of frame 1 from the start of frame 2. Two o_tx_done pulses.
- Pulse i_tx_start and change i_data during DATA -> no effect. Frame carries the originally latched word.
- Assert i_reset during bit 3 of DATA -> o_tx=1, o_tx_ready=1, o_tx_done=0 without waiting for a clock edge. A new word sent after reset releases produces a clean frame.
- SB_TICK=32 -> stop period lasts 2 bit periods (128 clocks at tick/4). o_tx_ready does not reassert before then.
